// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline packet types, memory-access encodings and the memory-stage FSM states.
// Also provides helpers that classify an access by width and alignment.
package rv32_pkg;

    typedef struct packed {
        logic        read_enable;
        logic        write_enable;
        logic [31:0] addr;
        logic [31:0] data;
    } rv32_mem_packet_t;

    typedef struct packed {
        logic [2:0] load_type;
        logic [1:0] store_type;
    } rv32_ex_control_packet_t;

    typedef struct packed {
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        wb_enable;
        logic [31:0] wb_pc;
    } rv32_ex2mem_wb_packet_t;

    typedef struct packed {
        logic        wb_valid;
        logic        wb_enable;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
    } rv32_mem2wb_packet_t;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b011;
    localparam logic [2:0] LOAD_LHU = 3'b100;

    localparam logic [1:0] STORE_SB = 2'b00;
    localparam logic [1:0] STORE_SH = 2'b01;
    localparam logic [1:0] STORE_SW = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_fsm_state_t;

    // log2 of the access width in bytes; unknown encodings are treated as word accesses
    function automatic logic [1:0] access_size_log2(input logic       is_store,
                                                    input logic [2:0] load_type,
                                                    input logic [1:0] store_type);
        logic [1:0] size_log2;
        size_log2 = 2'd2;
        if (is_store) begin
            case (store_type)
                STORE_SB: size_log2 = 2'd0;
                STORE_SH: size_log2 = 2'd1;
                default:  size_log2 = 2'd2;
            endcase
        end else begin
            case (load_type)
                LOAD_LB, LOAD_LBU: size_log2 = 2'd0;
                LOAD_LH, LOAD_LHU: size_log2 = 2'd1;
                default:           size_log2 = 2'd2;
            endcase
        end
        return size_log2;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size_log2, input logic [1:0] offset);
        logic bad;
        case (size_log2)
            2'd1:    bad = offset[0];
            2'd2:    bad = |offset;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align_extend.sv
// Load formatter: shifts the addressed byte/halfword down to bit 0 of the returned
// word and sign- or zero-extends it according to the load type.
module load_align_extend
    import rv32_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  load_type,
    output logic [31:0] result
);

    logic [31:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        case (load_type)
            LOAD_LB:  result = {{24{shifted[7]}}, shifted[7:0]};
            LOAD_LH:  result = {{16{shifted[15]}}, shifted[15:0]};
            LOAD_LBU: result = {24'b0, shifted[7:0]};
            LOAD_LHU: result = {16'b0, shifted[15:0]};
            default:  result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// RV32 memory stage: issues loads/stores on a ready/valid data port, formats load
// results, stalls EX while an access is outstanding and forwards non-memory results.
module mem_access_stage
    import rv32_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  rv32_mem_packet_t        mem_packet,
    input  rv32_ex_control_packet_t ex_control_packet,
    input  rv32_ex2mem_wb_packet_t  ex_wb_packet,
    output logic                    stall,
    output logic                    dmem_req_valid,
    input  logic                    dmem_req_ready,
    output logic                    dmem_req_we,
    output logic [31:0]             dmem_req_addr,
    output logic [31:0]             dmem_req_wdata,
    output logic [3:0]              dmem_req_wstrb,
    input  logic                    dmem_rsp_valid,
    input  logic [31:0]             dmem_rsp_rdata,
    output logic                    wb_valid,
    output logic                    wb_enable,
    output logic [4:0]              wb_addr,
    output logic [31:0]             wb_data,
    output logic                    misalign_err,
    output logic                    bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_fsm_state_t      state_reg, state_next;
    logic [CNT_W-1:0]    wait_cnt_reg, wait_cnt_next;
    rv32_mem2wb_packet_t wb_reg, wb_next;
    logic                misalign_err_reg, misalign_err_next;
    logic                bus_err_reg, bus_err_next;
    logic                latch_en;

    logic [31:0] req_addr_reg;
    logic        req_we_reg;
    logic [31:0] req_wdata_reg;
    logic [3:0]  req_wstrb_reg;
    logic [1:0]  offset_reg;
    logic [2:0]  load_type_reg;
    logic [4:0]  dest_reg;

    logic        is_memop;
    logic        is_store_in;
    logic [1:0]  size_log2_in;
    logic [1:0]  offset_in;
    logic        misaligned_in;
    logic [3:0]  store_wstrb;
    logic [31:0] store_wdata;
    logic [31:0] load_result;
    logic        timeout;

    assign is_memop      = mem_packet.read_enable | mem_packet.write_enable;
    assign is_store_in   = mem_packet.write_enable;
    assign offset_in     = mem_packet.addr[1:0];
    assign size_log2_in  = access_size_log2(is_store_in, ex_control_packet.load_type,
                                            ex_control_packet.store_type);
    assign misaligned_in = is_misaligned(size_log2_in, offset_in);

    always_comb begin
        case (size_log2_in)
            2'd0:    store_wstrb = 4'b0001 << offset_in;
            2'd1:    store_wstrb = 4'b0011 << offset_in;
            default: store_wstrb = 4'b1111;
        endcase
    end

    // Replicate the store datum across every lane so the strobes alone pick the target bytes
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_store_lane
            assign store_wdata[8*gi +: 8] =
                (size_log2_in == 2'd0) ? mem_packet.data[7:0] :
                (size_log2_in == 2'd1) ? mem_packet.data[8*(gi % 2) +: 8] :
                                         mem_packet.data[8*gi +: 8];
        end
    endgenerate

    load_align_extend u_load_align_extend (
        .rdata     (dmem_rsp_rdata),
        .offset    (offset_reg),
        .load_type (load_type_reg),
        .result    (load_result)
    );

    assign timeout = (state_reg == WAIT) && (wait_cnt_reg == LAST_CNT);

    always_comb begin
        state_next        = state_reg;
        wait_cnt_next     = wait_cnt_reg;
        stall             = 1'b0;
        latch_en          = 1'b0;
        misalign_err_next = 1'b0;
        bus_err_next      = 1'b0;
        wb_next           = '{wb_valid: 1'b0, wb_enable: 1'b0,
                              wb_addr: wb_reg.wb_addr, wb_data: wb_reg.wb_data};
        case (state_reg)
            IDLE: begin
                wait_cnt_next = '0;
                if (in_valid) begin
                    if (is_memop) begin
                        if (misaligned_in) begin
                            misalign_err_next = 1'b1;
                        end else begin
                            latch_en   = 1'b1;
                            stall      = 1'b1;
                            state_next = REQ;
                        end
                    end else begin
                        wb_next.wb_valid  = 1'b1;
                        wb_next.wb_enable = ex_wb_packet.wb_enable;
                        wb_next.wb_addr   = ex_wb_packet.wb_addr;
                        wb_next.wb_data   = ex_wb_packet.wb_data;
                    end
                end
            end
            REQ: begin
                stall = ~(req_we_reg & dmem_req_ready);
                if (dmem_req_ready) begin
                    if (req_we_reg) begin
                        state_next       = IDLE;
                        wb_next.wb_valid = 1'b1;
                        wb_next.wb_addr  = dest_reg;
                    end else begin
                        state_next    = WAIT;
                        wait_cnt_next = '0;
                    end
                end
            end
            WAIT: begin
                stall = ~dmem_rsp_valid & ~timeout;
                if (dmem_rsp_valid) begin
                    state_next        = IDLE;
                    wait_cnt_next     = '0;
                    wb_next.wb_valid  = 1'b1;
                    wb_next.wb_enable = 1'b1;
                    wb_next.wb_addr   = dest_reg;
                    wb_next.wb_data   = load_result;
                end else if (timeout) begin
                    state_next    = IDLE;
                    wait_cnt_next = '0;
                    bus_err_next  = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            wait_cnt_reg     <= '0;
            wb_reg           <= '0;
            misalign_err_reg <= 1'b0;
            bus_err_reg      <= 1'b0;
            req_addr_reg     <= '0;
            req_we_reg       <= 1'b0;
            req_wdata_reg    <= '0;
            req_wstrb_reg    <= '0;
            offset_reg       <= '0;
            load_type_reg    <= '0;
            dest_reg         <= '0;
        end else begin
            state_reg        <= state_next;
            wait_cnt_reg     <= wait_cnt_next;
            wb_reg           <= wb_next;
            misalign_err_reg <= misalign_err_next;
            bus_err_reg      <= bus_err_next;
            if (latch_en) begin
                req_addr_reg  <= {mem_packet.addr[31:2], 2'b00};
                req_we_reg    <= is_store_in;
                req_wdata_reg <= is_store_in ? store_wdata : 32'd0;
                req_wstrb_reg <= is_store_in ? store_wstrb : 4'b0000;
                offset_reg    <= offset_in;
                load_type_reg <= ex_control_packet.load_type;
                dest_reg      <= ex_wb_packet.wb_addr;
            end
        end
    end

    // The PC travels with the writeback packet but is not needed past this stage
    logic unused_wb_pc;
    assign unused_wb_pc = ^ex_wb_packet.wb_pc;

    assign dmem_req_valid = (state_reg == REQ);
    assign dmem_req_we    = req_we_reg;
    assign dmem_req_addr  = req_addr_reg;
    assign dmem_req_wdata = req_wdata_reg;
    assign dmem_req_wstrb = req_wstrb_reg;
    assign wb_valid       = wb_reg.wb_valid;
    assign wb_enable      = wb_reg.wb_enable;
    assign wb_addr        = wb_reg.wb_addr;
    assign wb_data        = wb_reg.wb_data;
    assign misalign_err   = misalign_err_reg;
    assign bus_err        = bus_err_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed corner cases plus randomized
// loads, stores and pass-through ops checked against an arithmetic reference model.
module tb_mem_access_stage;
    import rv32_pkg::*;

    localparam int TO = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    rv32_mem_packet_t        mem_packet;
    rv32_ex_control_packet_t ex_control_packet;
    rv32_ex2mem_wb_packet_t  ex_wb_packet;
    logic                    stall;
    logic                    dmem_req_valid;
    logic                    dmem_req_ready;
    logic                    dmem_req_we;
    logic [31:0]             dmem_req_addr;
    logic [31:0]             dmem_req_wdata;
    logic [3:0]              dmem_req_wstrb;
    logic                    dmem_rsp_valid;
    logic [31:0]             dmem_rsp_rdata;
    logic                    wb_valid;
    logic                    wb_enable;
    logic [4:0]              wb_addr;
    logic [31:0]             wb_data;
    logic                    misalign_err;
    logic                    bus_err;

    int checks = 0;
    int errors = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .mem_packet        (mem_packet),
        .ex_control_packet (ex_control_packet),
        .ex_wb_packet      (ex_wb_packet),
        .stall             (stall),
        .dmem_req_valid    (dmem_req_valid),
        .dmem_req_ready    (dmem_req_ready),
        .dmem_req_we       (dmem_req_we),
        .dmem_req_addr     (dmem_req_addr),
        .dmem_req_wdata    (dmem_req_wdata),
        .dmem_req_wstrb    (dmem_req_wstrb),
        .dmem_rsp_valid    (dmem_rsp_valid),
        .dmem_rsp_rdata    (dmem_rsp_rdata),
        .wb_valid          (wb_valid),
        .wb_enable         (wb_enable),
        .wb_addr           (wb_addr),
        .wb_data           (wb_data),
        .misalign_err      (misalign_err),
        .bus_err           (bus_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int model_size(input bit is_store, input logic [2:0] lt, input logic [1:0] st);
        if (is_store) return (st == 2'd0) ? 1 : (st == 2'd1) ? 2 : 4;
        return (lt == 3'd0 || lt == 3'd3) ? 1 : (lt == 3'd1 || lt == 3'd4) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rdata, input int offset, input logic [2:0] lt);
        int unsigned b, h;
        b = (rdata >> (8 * offset)) & 32'hFF;
        h = (rdata >> (8 * offset)) & 32'hFFFF;
        case (lt)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd3:    return b;
            3'd4:    return h;
            default: return rdata;
        endcase
    endfunction

    function automatic logic [3:0] model_wstrb(input int size, input int offset);
        return 4'(((1 << size) - 1) << offset);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] data, input int size);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = data[8*(k % size) +: 8];
        return w;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid          = 1'b0;
        mem_packet        = '0;
        ex_control_packet = '0;
        ex_wb_packet      = '0;
        dmem_req_ready    = 1'b0;
        dmem_rsp_valid    = 1'b0;
        dmem_rsp_rdata    = '0;
    endtask

    task automatic drive_pkt(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                             input logic [2:0] lt, input logic [1:0] st, input logic [4:0] wa,
                             input logic [31:0] wd, input logic we);
        in_valid          = 1'b1;
        mem_packet        = '{read_enable: rd, write_enable: wr, addr: addr, data: data};
        ex_control_packet = '{load_type: lt, store_type: st};
        ex_wb_packet      = '{wb_addr: wa, wb_data: wd, wb_enable: we, wb_pc: $urandom};
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        @(negedge clk);
        checks++; if (dmem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", dmem_req_valid); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
        checks++; if ({stall, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_wstrb, wb_enable, wb_addr, wb_data, misalign_err, bus_err} !== '0) begin
            errors++; $display("FAIL reset_outputs: got addr=%h wdata=%h wstrb=%b wb_data=%h stall=%b want all zero",
                               dmem_req_addr, dmem_req_wdata, dmem_req_wstrb, wb_data, stall);
        end
        rst = 1'b0;
        cyc();
        $display("txn reset done");
    endtask

    task automatic test_lw_latency();
        drive_pkt(1'b1, 1'b0, 32'h100, 32'h0, LOAD_LW, STORE_SB, 5'd7, 32'h0, 1'b0);
        @(negedge clk);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lw_idle_stall: got %b want 1", stall); end
        cyc();
        dmem_req_ready = 1'b1;
        @(negedge clk);
        checks++; if ({dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wstrb} !== {1'b1, 1'b0, 32'h100, 4'b0000}) begin
            errors++; $display("FAIL lw_req: got v=%b we=%b addr=%h wstrb=%b want v=1 we=0 addr=00000100 wstrb=0000",
                               dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wstrb);
        end
        cyc();
        dmem_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if ({stall, wb_valid} !== 2'b10) begin errors++; $display("FAIL lw_wait_%0d: got stall=%b wb_valid=%b want 1/0", i, stall, wb_valid); end
            cyc();
        end
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lw_rsp_stall: got %b want 0", stall); end
        cyc();
        idle_inputs();
        @(negedge clk);
        checks++; if ({wb_valid, wb_enable, wb_addr, wb_data} !== {1'b1, 1'b1, 5'd7, 32'hDEADBEEF}) begin
            errors++; $display("FAIL lw_wb: got v=%b en=%b addr=%0d data=%h want 1 1 7 deadbeef", wb_valid, wb_enable, wb_addr, wb_data);
        end
        cyc();
        @(negedge clk);
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL lw_wb_pulse: got %b want 0", wb_valid); end
        $display("txn LW 0x100 -> %h", 32'hDEADBEEF);
    endtask

    task automatic test_load_extend();
        logic [31:0] addrs [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
        logic [2:0]  types [4] = '{LOAD_LB, LOAD_LBU, LOAD_LH, LOAD_LHU};
        logic [31:0] exps  [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
        for (int i = 0; i < 4; i++) begin
            drive_pkt(1'b1, 1'b0, addrs[i], 32'h0, types[i], STORE_SB, 5'(i + 1), 32'h0, 1'b0);
            cyc();
            dmem_req_ready = 1'b1;
            cyc();
            dmem_req_ready = 1'b0;
            dmem_rsp_valid = 1'b1;
            dmem_rsp_rdata = 32'h80FFFFFF;
            cyc();
            idle_inputs();
            @(negedge clk);
            checks++; if ({wb_valid, wb_data} !== {1'b1, exps[i]}) begin
                errors++; $display("FAIL load_ext_%0d: got v=%b data=%h want 1 %h", i, wb_valid, wb_data, exps[i]);
            end
            $display("txn load type=%0d addr=%h -> %h", types[i], addrs[i], wb_data);
            cyc();
        end
    endtask

    task automatic test_store_sh();
        drive_pkt(1'b0, 1'b1, 32'h202, 32'h0000ABCD, LOAD_LB, STORE_SH, 5'd9, 32'h0, 1'b1);
        cyc();
        dmem_req_ready = 1'b1;
        @(negedge clk);
        checks++; if ({dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_wstrb} !== {1'b1, 1'b1, 32'h200, 32'hABCDABCD, 4'b1100}) begin
            errors++; $display("FAIL sh_req: got v=%b we=%b addr=%h wdata=%h wstrb=%b want 1 1 00000200 abcdabcd 1100",
                               dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_wstrb);
        end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sh_stall: got %b want 0", stall); end
        cyc();
        idle_inputs();
        @(negedge clk);
        checks++; if ({wb_valid, wb_enable, dmem_req_valid} !== 3'b100) begin
            errors++; $display("FAIL sh_wb: got v=%b en=%b req=%b want 1 0 0", wb_valid, wb_enable, dmem_req_valid);
        end
        cyc();
        $display("txn SH 0x202 data=0000abcd");
    endtask

    task automatic test_misalign();
        drive_pkt(1'b1, 1'b0, 32'h101, 32'h0, LOAD_LW, STORE_SB, 5'd3, 32'h0, 1'b0);
        @(negedge clk);
        checks++; if ({stall, dmem_req_valid} !== 2'b00) begin errors++; $display("FAIL mis_stall: got stall=%b req=%b want 0 0", stall, dmem_req_valid); end
        cyc();
        idle_inputs();
        @(negedge clk);
        checks++; if ({misalign_err, wb_valid, dmem_req_valid} !== 3'b100) begin
            errors++; $display("FAIL mis_pulse: got err=%b wb=%b req=%b want 1 0 0", misalign_err, wb_valid, dmem_req_valid);
        end
        cyc();
        @(negedge clk);
        checks++; if ({misalign_err, dmem_req_valid} !== 2'b00) begin errors++; $display("FAIL mis_clear: got err=%b req=%b want 0 0", misalign_err, dmem_req_valid); end
        $display("txn LW 0x101 misaligned");
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        d = $urandom;
        drive_pkt(1'b0, 1'b1, 32'h300, d, LOAD_LB, STORE_SW, 5'd4, 32'h0, 1'b0);
        cyc();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if ({dmem_req_valid, stall, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_wstrb} !== {1'b1, 1'b1, 1'b1, 32'h300, d, 4'b1111}) begin
                errors++; $display("FAIL bp_hold_%0d: got v=%b stall=%b addr=%h wdata=%h wstrb=%b want 1 1 00000300 %h 1111",
                                   i, dmem_req_valid, stall, dmem_req_addr, dmem_req_wdata, dmem_req_wstrb, d);
            end
            cyc();
        end
        dmem_req_ready = 1'b1;
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL bp_release: got stall=%b want 0", stall); end
        cyc();
        idle_inputs();
        @(negedge clk);
        checks++; if ({wb_valid, wb_enable} !== 2'b10) begin errors++; $display("FAIL bp_wb: got v=%b en=%b want 1 0", wb_valid, wb_enable); end
        cyc();
        $display("txn SW 0x300 after 5 wait cycles");
    endtask

    task automatic test_timeout();
        drive_pkt(1'b1, 1'b0, 32'h400, 32'h0, LOAD_LW, STORE_SB, 5'd5, 32'h0, 1'b0);
        cyc();
        dmem_req_ready = 1'b1;
        cyc();
        dmem_req_ready = 1'b0;
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            checks++; if (stall !== (i < TO - 1)) begin errors++; $display("FAIL to_stall_%0d: got %b want %b", i, stall, (i < TO - 1)); end
            cyc();
        end
        idle_inputs();
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'h12345678;
        @(negedge clk);
        checks++; if ({bus_err, wb_valid, dmem_req_valid, stall} !== 4'b1000) begin
            errors++; $display("FAIL to_buserr: got err=%b wb=%b req=%b stall=%b want 1 0 0 0", bus_err, wb_valid, dmem_req_valid, stall);
        end
        cyc();
        dmem_rsp_valid = 1'b0;
        @(negedge clk);
        checks++; if ({bus_err, wb_valid} !== 2'b00) begin errors++; $display("FAIL to_after: got err=%b wb=%b want 0 0", bus_err, wb_valid); end
        cyc();
        $display("txn LW 0x400 timed out");
    endtask

    task automatic test_reset_in_wait();
        drive_pkt(1'b1, 1'b0, 32'h500, 32'h0, LOAD_LW, STORE_SB, 5'd6, 32'h0, 1'b0);
        cyc();
        dmem_req_ready = 1'b1;
        cyc();
        dmem_req_ready = 1'b0;
        cyc();
        idle_inputs();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'hCAFEF00D;
        @(negedge clk);
        checks++; if ({dmem_req_valid, stall, wb_valid} !== 3'b000) begin
            errors++; $display("FAIL rstw_state: got req=%b stall=%b wb=%b want 0 0 0", dmem_req_valid, stall, wb_valid);
        end
        for (int i = 0; i < 2; i++) begin
            cyc();
            dmem_rsp_valid = 1'b0;
            @(negedge clk);
            checks++; if ({wb_valid, bus_err, dmem_req_valid} !== 3'b000) begin
                errors++; $display("FAIL rstw_late_%0d: got wb=%b err=%b req=%b want 0 0 0", i, wb_valid, bus_err, dmem_req_valid);
            end
        end
        cyc();
        $display("txn reset during WAIT");
    endtask

    task automatic test_back_to_back();
        logic [4:0]  pa, ca;
        logic [31:0] pd, cd;
        logic        pe, ce;
        pa = '0; pd = '0; pe = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ca = 5'($urandom); cd = $urandom; ce = 1'($urandom);
            drive_pkt(1'b0, 1'b0, $urandom, $urandom, 3'($urandom), 2'($urandom), ca, cd, ce);
            @(negedge clk);
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall_%0d: got %b want 0", i, stall); end
            if (i > 0) begin
                checks++; if ({wb_valid, wb_enable, wb_addr, wb_data} !== {1'b1, pe, pa, pd}) begin
                    errors++; $display("FAIL b2b_wb_%0d: got v=%b en=%b addr=%0d data=%h want 1 %b %0d %h", i, wb_valid, wb_enable, wb_addr, wb_data, pe, pa, pd);
                end
            end
            $display("txn passthrough %0d addr=%0d data=%h en=%b", i, ca, cd, ce);
            pa = ca; pd = cd; pe = ce;
            cyc();
        end
        idle_inputs();
        @(negedge clk);
        checks++; if ({wb_valid, wb_enable, wb_addr, wb_data} !== {1'b1, pe, pa, pd}) begin
            errors++; $display("FAIL b2b_wb_last: got v=%b en=%b addr=%0d data=%h want 1 %b %0d %h", wb_valid, wb_enable, wb_addr, wb_data, pe, pa, pd);
        end
        cyc();
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            int          kind, sz, off, rd_lat, rsp_lat;
            logic [31:0] addr, data, rdata, wbd;
            logic [2:0]  lt;
            logic [1:0]  st;
            logic [4:0]  dest;
            logic        wbe;
            bit          is_st, mis;
            kind    = $urandom_range(0, 2);
            addr    = $urandom;
            data    = $urandom;
            rdata   = $urandom;
            wbd     = $urandom;
            wbe     = 1'($urandom);
            lt      = 3'($urandom_range(0, 4));
            st      = 2'($urandom_range(0, 2));
            dest    = 5'($urandom);
            is_st   = (kind == 2);
            sz      = model_size(is_st, lt, st);
            off     = int'(addr % 4);
            mis     = (kind != 0) && ((off % sz) != 0);
            rd_lat  = $urandom_range(0, 2);
            rsp_lat = $urandom_range(0, TO - 1);
            if (kind == 0)      drive_pkt(1'b0, 1'b0, addr, data, lt, st, dest, wbd, wbe);
            else if (kind == 1) drive_pkt(1'b1, 1'b0, addr, data, lt, st, dest, wbd, wbe);
            else                drive_pkt(1'($urandom), 1'b1, addr, data, lt, st, dest, wbd, wbe);
            $display("txn rnd %0d kind=%0d addr=%h lt=%0d st=%0d mis=%0d", t, kind, addr, lt, st, mis);
            @(negedge clk);
            checks++; if (stall !== (kind != 0 && !mis)) begin errors++; $display("FAIL rnd%0d_issue_stall: got %b want %b", t, stall, (kind != 0 && !mis)); end
            if (kind == 0) begin
                cyc();
                idle_inputs();
                @(negedge clk);
                checks++; if ({wb_valid, wb_enable, wb_addr, wb_data} !== {1'b1, wbe, dest, wbd}) begin
                    errors++; $display("FAIL rnd%0d_pass: got v=%b en=%b addr=%0d data=%h want 1 %b %0d %h", t, wb_valid, wb_enable, wb_addr, wb_data, wbe, dest, wbd);
                end
            end else if (mis) begin
                cyc();
                idle_inputs();
                @(negedge clk);
                checks++; if ({misalign_err, wb_valid, dmem_req_valid} !== 3'b100) begin
                    errors++; $display("FAIL rnd%0d_mis: got err=%b wb=%b req=%b want 1 0 0", t, misalign_err, wb_valid, dmem_req_valid);
                end
            end else begin
                cyc();
                for (int r = 0; r <= rd_lat; r++) begin
                    dmem_req_ready = (r == rd_lat);
                    dmem_rsp_valid = 1'($urandom);
                    @(negedge clk);
                    checks++; if ({dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wstrb} !==
                                  {1'b1, is_st, addr & 32'hFFFF_FFFC, is_st ? model_wstrb(sz, off) : 4'b0000}) begin
                        errors++; $display("FAIL rnd%0d_req: got v=%b we=%b addr=%h wstrb=%b want 1 %b %h %b", t, dmem_req_valid, dmem_req_we,
                                           dmem_req_addr, dmem_req_wstrb, is_st, addr & 32'hFFFF_FFFC, is_st ? model_wstrb(sz, off) : 4'b0000);
                    end
                    if (is_st) begin
                        checks++; if (dmem_req_wdata !== model_wdata(data, sz)) begin
                            errors++; $display("FAIL rnd%0d_wdata: got %h want %h", t, dmem_req_wdata, model_wdata(data, sz));
                        end
                    end
                    checks++; if (stall !== !(is_st && r == rd_lat)) begin errors++; $display("FAIL rnd%0d_req_stall: got %b want %b", t, stall, !(is_st && r == rd_lat)); end
                    cyc();
                end
                dmem_req_ready = 1'b0;
                dmem_rsp_valid = 1'b0;
                if (!is_st) begin
                    for (int w = 0; w <= rsp_lat; w++) begin
                        dmem_rsp_valid = (w == rsp_lat);
                        dmem_rsp_rdata = (w == rsp_lat) ? rdata : $urandom;
                        @(negedge clk);
                        checks++; if (stall !== (w != rsp_lat)) begin errors++; $display("FAIL rnd%0d_wait_stall: got %b want %b", t, stall, (w != rsp_lat)); end
                        cyc();
                    end
                end
                idle_inputs();
                @(negedge clk);
                if (is_st) begin
                    checks++; if ({wb_valid, wb_enable} !== 2'b10) begin errors++; $display("FAIL rnd%0d_st_wb: got v=%b en=%b want 1 0", t, wb_valid, wb_enable); end
                end else begin
                    checks++; if ({wb_valid, wb_enable, wb_addr, wb_data} !== {1'b1, 1'b1, dest, model_load(rdata, off, lt)}) begin
                        errors++; $display("FAIL rnd%0d_ld_wb: got v=%b en=%b addr=%0d data=%h want 1 1 %0d %h", t, wb_valid, wb_enable,
                                           wb_addr, wb_data, dest, model_load(rdata, off, lt));
                    end
                end
            end
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_lw_latency();
        test_load_extend();
        test_store_sh();
        test_misalign();
        test_backpressure();
        test_timeout();
        test_reset_in_wait();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
